// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address sequencers: state encoding, default size
// and a width-generic bit-reverse helper.
package fft_pkg;

    localparam int DEFAULT_LOG2N = 6;
    localparam int MAX_WIDTH     = 16;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_COUNT = ST_COUNT
    } seq_state_t;

    // Reverses the low 'width' bits of value; bits at and above 'width' come back zero.
    function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] value,
                                                     input int width);
        logic [MAX_WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                result[i] = value[width-1-i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational bit-order reversal of a WIDTH-bit word.
module bit_reverse #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] reversed
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign reversed[gi] = value[WIDTH-1-gi];
        end
    endgenerate

endmodule

// File: rtl/fft_output_sequencer.sv
// Walks one 2**LOG2N-point FFT result frame out of the result memory with
// backpressure, framing strobes, one queued frame and sticky overrun reporting.
module fft_output_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N  = DEFAULT_LOG2N,
    parameter int BITREV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dataind,
    input  logic             ready,
    input  logic             clr_err,
    output logic [LOG2N-1:0] counter_o,
    output logic [LOG2N-1:0] addr_o,
    output logic             datavalid,
    output logic             sof,
    output logic             eof,
    output logic             frame_done,
    output logic             overrun,
    output logic             busy
);

    localparam logic [LOG2N-1:0] LAST_INDEX = '1;

    seq_state_t       state_reg;
    logic [LOG2N-1:0] count_reg;
    logic             pending_reg;
    logic             sof_reg;
    logic             done_reg;
    logic             overrun_reg;

    logic accept;
    logic last_beat;
    logic overrun_set;

    assign accept      = (state_reg == S_COUNT) && ready;
    assign last_beat   = accept && (count_reg == LAST_INDEX);
    // A request that cannot be absorbed by the final beat and finds the queue slot taken.
    assign overrun_set = dataind && (state_reg == S_COUNT) && !last_beat && pending_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            pending_reg <= 1'b0;
            sof_reg     <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (clr_err) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (dataind) begin
                        state_reg <= S_COUNT;
                        count_reg <= '0;
                        sof_reg   <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (last_beat) begin
                        count_reg <= '0;
                        done_reg  <= 1'b1;
                        if (dataind || pending_reg) begin
                            sof_reg     <= 1'b1;
                            pending_reg <= 1'b0;
                        end else begin
                            state_reg <= S_IDLE;
                            sof_reg   <= 1'b0;
                        end
                    end else begin
                        if (accept) begin
                            count_reg <= count_reg + 1'b1;
                            sof_reg   <= 1'b0;
                        end
                        if (dataind && !pending_reg) begin
                            pending_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign counter_o  = count_reg;
    assign datavalid  = (state_reg == S_COUNT);
    assign busy       = (state_reg == S_COUNT);
    assign sof        = sof_reg;
    assign eof        = (state_reg == S_COUNT) && (count_reg == LAST_INDEX);
    assign frame_done = done_reg;
    assign overrun    = overrun_reg;

    generate
        if (BITREV != 0) begin : g_rev
            bit_reverse #(
                .WIDTH(LOG2N)
            ) u_rev (
                .value   (count_reg),
                .reversed(addr_o)
            );
        end else begin : g_nat
            assign addr_o = count_reg;
        end
    endgenerate

endmodule
